// File: rtl/count_ones_host.sv
// rtl/count_ones_host.sv - host side of the count_ones handshake: input FIFO, presenter FSM, result buffer, running total.
// Optional build macro ONES_CHECK_EN adds a sticky check_err output that cross-checks bit_count against data.
module count_ones_host #(
  parameter int word_size      = 4,
  parameter int counter_size   = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int TOTAL_SIZE     = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [word_size-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [word_size-1:0]    data,
  input  logic                    start,
  input  logic                    done,
  input  logic [counter_size-1:0] bit_count,
  output logic [word_size-1:0]    res_word,
  output logic [counter_size-1:0] res_count,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [TOTAL_SIZE-1:0]   total,
`ifdef ONES_CHECK_EN
  output logic                    check_err,
`endif
  output logic                    timeout_err
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PRESENT, BUSY, RESULT} state_t;

  state_t                  state_q, state_d;
  logic [word_size-1:0]    mem_q [FIFO_DEPTH];
  logic [word_size-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]          cnt_q, cnt_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [word_size-1:0]    data_q, data_d, res_word_q, res_word_d;
  logic [counter_size-1:0] res_count_q, res_count_d;
  logic                    res_valid_q, res_valid_d;
  logic [TOTAL_SIZE-1:0]   total_q, total_d;
  logic [TOTAL_SIZE:0]     total_sum;
  logic                    timeout_err_q, timeout_err_d;

  logic fifo_full, fifo_empty, push, pop, waiting, capture, timeout_hit;

  assign fifo_full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = in_valid && !fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign waiting    = (state_q == PRESENT) || (state_q == BUSY);
  // start and done together in PRESENT capture straight away, skipping BUSY
  assign capture    = ((state_q == PRESENT) && start && done) || ((state_q == BUSY) && done);
  assign timeout_hit = waiting && !capture && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = PRESENT;
      PRESENT: begin
        if (capture)          state_d = RESULT;
        else if (timeout_hit) state_d = IDLE;
        else if (start)       state_d = BUSY;
      end
      BUSY: begin
        if (capture)          state_d = RESULT;
        else if (timeout_hit) state_d = IDLE;
      end
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ONES_CHECK_EN
  logic                    check_err_q, check_err_d;
  logic [counter_size-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < word_size; i++) ones = ones + counter_size'(data_q[i]);
    check_err_d = check_err_q;
    if (capture && (bit_count != ones)) check_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) check_err_q <= 1'b0;
    else        check_err_q <= check_err_d;
  end

  assign check_err = check_err_q;
`endif

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    data_d        = data_q;
    res_word_d    = res_word_q;
    res_count_d   = res_count_q;
    res_valid_d   = res_valid_q;
    total_d       = total_q;
    timeout_err_d = timeout_err_q;
    total_sum     = {1'b0, total_q} + (TOTAL_SIZE+1)'(bit_count);

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      data_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
      wait_d   = '0;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (waiting && !capture) wait_d = wait_q + 1'b1;
    if (timeout_hit) timeout_err_d = 1'b1;

    if (capture) begin
      res_count_d = bit_count;
      res_word_d  = data_q;
      res_valid_d = 1'b1;
      total_d     = total_sum[TOTAL_SIZE] ? '1 : total_sum[TOTAL_SIZE-1:0];
    end
    if ((state_q == RESULT) && res_ready) res_valid_d = 1'b0;
  end

  // FIFO storage needs no reset: the pointers and count define its contents
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      wait_q        <= '0;
      data_q        <= '0;
      res_word_q    <= '0;
      res_count_q   <= '0;
      res_valid_q   <= 1'b0;
      total_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      data_q        <= data_d;
      res_word_q    <= res_word_d;
      res_count_q   <= res_count_d;
      res_valid_q   <= res_valid_d;
      total_q       <= total_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign data        = data_q;
  assign res_word    = res_word_q;
  assign res_count   = res_count_q;
  assign res_valid   = res_valid_q;
  assign total       = total_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_count_ones_host.sv
// tb/tb_count_ones_host.sv - scoreboard bench for count_ones_host with a behavioural counter model.
module tb_count_ones_host;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] data;
  logic       start;
  logic       done;
  logic [2:0] bit_count;
  logic [3:0] res_word;
  logic [2:0] res_count;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] total;
  logic       timeout_err;
`ifdef ONES_CHECK_EN
  logic       check_err;
`endif

  count_ones_host dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data        (data),
    .start       (start),
    .done        (done),
    .bit_count   (bit_count),
    .res_word    (res_word),
    .res_count   (res_count),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .total       (total),
`ifdef ONES_CHECK_EN
    .check_err   (check_err),
`endif
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] w;
    logic [2:0] c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_total = 0;

  bit         emu_en = 1'b0;
  int         emu_mode = 0;
  logic       man_start = 1'b0;
  logic       man_done = 1'b0;
  logic [2:0] man_count = '0;

  function automatic logic [2:0] ones4(input logic [3:0] w);
    return 3'($countones(w));
  endfunction

  // Counter model: sole driver of start/done/bit_count, updated 2 time units after each edge
  initial begin
    start = 1'b0;
    done = 1'b0;
    bit_count = '0;
    forever begin
      @(posedge clk);
      #2;
      if (emu_en) begin
        start = 1'b1;
        done = (emu_mode == 0) ? 1'b1 : ~done;
        bit_count = ones4(data);
      end else begin
        start = man_start;
        done = man_done;
        bit_count = man_count;
      end
    end
  end

  // Result monitor: every accepted result is compared against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: word=%h count=%0d, scoreboard empty", res_word, res_count);
        end else begin
          e = sb.pop_front();
          checks++;
          if (res_word !== e.w || res_count !== e.c) begin
            errors++;
            $display("FAIL result: got word=%h count=%0d, expected word=%h count=%0d", res_word, res_count, e.w, e.c);
          end
          exp_total = exp_total + int'(e.c);
          if (exp_total > 255) exp_total = 255;
          checks++;
          if (total !== 8'(exp_total)) begin
            errors++;
            $display("FAIL total_running: got %0d, expected %0d", total, exp_total);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    res_ready = 1'b0;
    emu_en = 1'b0;
    man_start = 1'b0;
    man_done = 1'b0;
    man_count = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    exp_total = 0;
  endtask

  task automatic push_word(input logic [3:0] w, input logic [2:0] c, input bit expect_result, input int max_wait);
    int waited = 0;
    in_data = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < max_wait) begin
      waited++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL push_accept: word=%h in_ready=%b after %0d cycles, expected 1", w, in_ready, waited);
    end else if (expect_result) begin
      sb.push_back('{w: w, c: c});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || res_valid) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || res_valid) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, res_valid=%b, expected 0 and 0", sb.size(), res_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || data !== 4'h0 || res_valid !== 1'b0 || res_word !== 4'h0 ||
        res_count !== 3'd0 || total !== 8'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b data=%h res_valid=%b res_word=%h res_count=%0d total=%0d timeout_err=%b, expected 1 0 0 0 0 0 0",
               in_ready, data, res_valid, res_word, res_count, total, timeout_err);
    end
`ifdef ONES_CHECK_EN
    checks++;
    if (check_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_check_err: got %b, expected 0", check_err);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    res_ready = 1'b0;
    push_word(4'hf, 3'd4, 1'b1, 2);
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (data !== 4'hf) begin
      errors++;
      $display("FAIL single_data: got %h, expected f", data);
    end
    @(posedge clk);
    #1;
    man_start = 1'b1;
    @(posedge clk);
    #1;
    man_start = 1'b0;
    man_done = 1'b1;
    man_count = 3'd4;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_word !== 4'hf || res_count !== 3'd4 || total !== 8'd4) begin
      errors++;
      $display("FAIL single_result: res_valid=%b res_word=%h res_count=%0d total=%0d, expected 1 f 4 4",
               res_valid, res_word, res_count, total);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain(20);
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [5];
    words = '{4'ha, 4'h5, 4'hb, 4'h9, 4'h0};
    do_reset();
    res_ready = 1'b1;
    emu_en = 1'b1;
    emu_mode = 0;
    for (int i = 0; i < 5; i++) push_word(words[i], ones4(words[i]), 1'b1, 0);
    drain(60);
    emu_en = 1'b0;
    checks++;
    if (total !== 8'd9) begin
      errors++;
      $display("FAIL b2b_total: got %0d, expected 9", total);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] words [6];
    logic [3:0] held_w;
    logic [2:0] held_c;
    words = '{4'h1, 4'h3, 4'h7, 4'he, 4'hc, 4'h8};
    do_reset();
    res_ready = 1'b0;
    emu_en = 1'b1;
    emu_mode = 1;
    for (int i = 0; i < 5; i++) push_word(words[i], ones4(words[i]), 1'b1, 0);
    @(negedge clk);
    held_w = res_word;
    held_c = res_count;
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b1 || held_w !== 4'h1 || held_c !== 3'd1) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b res_valid=%b res_word=%h res_count=%0d, expected 0 1 1 1",
               in_ready, res_valid, held_w, held_c);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_word !== held_w || res_count !== held_c) begin
        errors++;
        $display("FAIL bp_hold: in_ready=%b res_valid=%b res_word=%h res_count=%0d, expected 0 1 %h %0d",
                 in_ready, res_valid, res_word, res_count, held_w, held_c);
      end
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    push_word(words[5], ones4(words[5]), 1'b1, 20);
    drain(80);
    emu_en = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    int total_before;
    res_ready = 1'b1;
    emu_en = 1'b0;
    total_before = exp_total;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pre: got %b, expected 0", timeout_err);
    end
    push_word(4'h3, 3'd2, 1'b0, 2);
    while (timeout_err !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 34) begin
      errors++;
      $display("FAIL timeout_latency: timeout_err=%b after %0d samples, expected 1 after 34", timeout_err, n);
    end
    checks++;
    if (total !== 8'(total_before) || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_drop: total=%0d res_valid=%b, expected %0d 0", total, res_valid, total_before);
    end
    @(posedge clk);
    #1;
    emu_en = 1'b1;
    emu_mode = 0;
    push_word(4'h6, 3'd2, 1'b1, 2);
    drain(30);
    emu_en = 1'b0;
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b, expected 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid_busy();
    emu_en = 1'b0;
    res_ready = 1'b1;
    push_word(4'hd, 3'd3, 1'b0, 2);
    @(posedge clk);
    #1;
    man_start = 1'b1;
    @(posedge clk);
    #1;
    man_start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (data !== 4'h0 || res_valid !== 1'b0 || res_word !== 4'h0 || res_count !== 3'd0 ||
        total !== 8'd0 || timeout_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midbusy_reset: data=%h res_valid=%b res_word=%h res_count=%0d total=%0d timeout_err=%b in_ready=%b, expected 0 0 0 0 0 0 1",
               data, res_valid, res_word, res_count, total, timeout_err, in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    exp_total = 0;
    man_done = 1'b1;
    man_count = 3'd3;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || data !== 4'h0 || total !== 8'd0) begin
        errors++;
        $display("FAIL late_done: res_valid=%b data=%h total=%0d, expected 0 0 0", res_valid, data, total);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_same_cycle();
    logic [2:0] cnt;
`ifdef ONES_CHECK_EN
    cnt = 3'd2;
    checks++;
    if (check_err !== 1'b0) begin
      errors++;
      $display("FAIL check_err_pre: got %b, expected 0", check_err);
    end
`else
    cnt = 3'd3;
`endif
    emu_en = 1'b0;
    res_ready = 1'b0;
    push_word(4'h7, cnt, 1'b1, 2);
    @(posedge clk);
    #1;
    man_start = 1'b1;
    man_done = 1'b1;
    man_count = cnt;
    @(posedge clk);
    #1;
    man_start = 1'b0;
    man_done = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_word !== 4'h7 || res_count !== cnt) begin
      errors++;
      $display("FAIL same_cycle: res_valid=%b res_word=%h res_count=%0d, expected 1 7 %0d", res_valid, res_word, res_count, cnt);
    end
`ifdef ONES_CHECK_EN
    checks++;
    if (check_err !== 1'b1) begin
      errors++;
      $display("FAIL check_err_set: got %b, expected 1", check_err);
    end
`endif
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain(20);
  endtask

  task automatic test_saturation();
    do_reset();
    res_ready = 1'b1;
    emu_en = 1'b1;
    emu_mode = 0;
    for (int i = 0; i < 70; i++) push_word(4'hf, 3'd4, 1'b1, 10);
    drain(100);
    emu_en = 1'b0;
    checks++;
    if (total !== 8'hff) begin
      errors++;
      $display("FAIL saturation: got %0d, expected 255", total);
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    res_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_busy();
    test_same_cycle();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
